niosii_system_sysid_checker: RTL

- Avalon-MM read master for the system-ID slave. On a start pulse it reads the ID word (address 0), then the timestamp word (address 1), and compares both against build-time expected values.
- Reports pass/fail/timeout to boot or status logic so the host can reject a mismatched FPGA image before loading software.

---
 rtl/niosii_system_sysid_checker.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/niosii_system_sysid_checker.sv
// Avalon-MM sysid reader: fetches ID and timestamp words and compares them.
// Optional automatic retry is enabled by defining SYSID_CHECKER_RETRY_EN.
module niosii_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h00000000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1425177068,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
`ifdef SYSID_CHECKER_RETRY_EN
    output logic [1:0]  retries_used,
`endif
    output logic [31:0] ts_value
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID_REQ,
        S_ID_DATA,
        S_TS_REQ,
        S_TS_DATA,
        S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic          read_q, read_d;
    logic          addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          to_q, to_d;
    logic [31:0]   id_q, id_d;
    logic [31:0]   ts_q, ts_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef SYSID_CHECKER_RETRY_EN
    logic [1:0]    retry_q, retry_d;
`endif

    logic is_ts;
    logic is_req;
    logic accept;
    logic capture;
    logic fin;
    logic fin_to;
    logic fin_ok;

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        to_d    = to_q;
        id_d    = id_q;
        ts_d    = ts_q;
        cnt_d   = cnt_q;
`ifdef SYSID_CHECKER_RETRY_EN
        retry_d = retry_q;
`endif
        is_ts   = 1'b0;
        is_req  = 1'b0;
        accept  = 1'b0;
        capture = 1'b0;
        fin     = 1'b0;
        fin_to  = 1'b0;
        fin_ok  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ID_REQ;
                    read_d  = 1'b1;
                    addr_d  = 1'b0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    to_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SYSID_CHECKER_RETRY_EN
                    retry_d = 2'd0;
`endif
                end
            end
            S_ID_REQ, S_ID_DATA, S_TS_REQ, S_TS_DATA: begin
                is_ts   = (state_q == S_TS_REQ) || (state_q == S_TS_DATA);
                is_req  = (state_q == S_ID_REQ) || (state_q == S_TS_REQ);
                accept  = is_req && !avm_waitrequest;
                // Data is only meaningful once the request has been accepted
                capture = avm_readdatavalid && (!is_req || accept);
                cnt_d   = cnt_q + 1'b1;
                if (capture) begin
                    cnt_d = '0;
                    if (is_ts) begin
                        ts_d = avm_readdata;
                        fin  = 1'b1;
                    end else begin
                        id_d    = avm_readdata;
                        state_d = S_TS_REQ;
                        read_d  = 1'b1;
                        addr_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    fin    = 1'b1;
                    fin_to = 1'b1;
                end else if (accept) begin
                    read_d  = 1'b0;
                    state_d = is_ts ? S_TS_DATA : S_ID_DATA;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin) begin
            fin_ok  = !fin_to && (id_d == EXPECTED_ID)
                      && (ts_d == EXPECTED_TIMESTAMP);
            state_d = S_FINISH;
            done_d  = 1'b1;
            pass_d  = fin_ok;
            to_d    = fin_to;
            read_d  = 1'b0;
            cnt_d   = '0;
`ifdef SYSID_CHECKER_RETRY_EN
            if (!fin_ok && retry_q != 2'd3) begin
                state_d = S_ID_REQ;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                to_d    = 1'b0;
                read_d  = 1'b1;
                addr_d  = 1'b0;
                retry_d = retry_q + 2'd1;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
            cnt_q   <= '0;
`ifdef SYSID_CHECKER_RETRY_EN
            retry_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            to_q    <= to_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            cnt_q   <= cnt_d;
`ifdef SYSID_CHECKER_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = to_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
`ifdef SYSID_CHECKER_RETRY_EN
    assign retries_used = retry_q;
`endif

endmodule
